// File: rtl/wb_pkg.sv
// Package for the write-back port arbiter.
// Holds the source/write-port counts, default widths and the buffered entry type.
package wb_pkg;

  localparam int unsigned NUM_SRC       = 4;
  localparam int unsigned NUM_WPORT     = 2;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus interface of the write-back port arbiter.
// Sources: src_valid_i/src_ready_o handshake plus per-source addr/data.
// Write ports: wr1_*/wr2_* enable, address and data; idle_o when all buffers empty.
// Modports: slave (arbiter side), master (source / register-file side).
interface wb_port_arbiter_if
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) ();

  logic [NUM_SRC-1:0]                 src_valid_i;
  logic [NUM_SRC-1:0]                 src_ready_o;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] src_addr_i;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data_i;
  logic                               wr1_en_o;
  logic                               wr2_en_o;
  logic [ADDR_WIDTH-1:0]              wr1_addr_o;
  logic [ADDR_WIDTH-1:0]              wr2_addr_o;
  logic [DATA_WIDTH-1:0]              wr1_data_o;
  logic [DATA_WIDTH-1:0]              wr2_data_o;
  logic                               idle_o;

  modport slave (
    input  src_valid_i, src_addr_i, src_data_i,
    output src_ready_o, wr1_en_o, wr2_en_o, wr1_addr_o, wr2_addr_o,
           wr1_data_o, wr2_data_o, idle_o
  );

  modport master (
    output src_valid_i, src_addr_i, src_data_i,
    input  src_ready_o, wr1_en_o, wr2_en_o, wr1_addr_o, wr2_addr_o,
           wr1_data_o, wr2_data_o, idle_o
  );

endinterface

// File: rtl/wb_src_fifo.sv
// Two-entry per-source result buffer.
// Ports: clk, rst (async active-high), push/wdata (ignored when full),
// pop (ignored when empty), head (oldest entry), count (0..2).
module wb_src_fifo
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     wdata,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push, do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop && (count_q != 2'd0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: buffers results from four sources (2-entry FIFO each)
// and grants up to two FIFO heads per cycle onto two registered register-file
// write ports, round-robin, never granting two heads with the same address.
// Ports: clk, rst (async active-high), bus (wb_port_arbiter_if.slave).
// Config macro WB_ZERO_DROP_EN: register-0 heads are popped without a write.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned RrWidth = $clog2(NUM_SRC);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

`ifdef WB_ZERO_DROP_EN
  localparam bit ZeroDrop = 1'b1;
`else
  localparam bit ZeroDrop = 1'b0;
`endif

  entry_t                               head  [NUM_SRC];
  entry_t                               wdata [NUM_SRC];
  logic [NUM_SRC-1:0][1:0]              count;
  logic [NUM_SRC-1:0]                   full, empty, push, pop;
  logic [RrWidth-1:0]                   rr_q, rr_d;
  logic [NUM_WPORT-1:0]                 wr_en_q, wr_en_d;
  logic [NUM_WPORT-1:0][ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [NUM_WPORT-1:0][DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign full[i]       = (count[i] == 2'd2);
    assign empty[i]      = (count[i] == 2'd0);
    assign push[i]       = bus.src_valid_i[i] & ~full[i];
    assign wdata[i].addr = bus.src_addr_i[i];
    assign wdata[i].data = bus.src_data_i[i];

    wb_src_fifo #(
      .entry_t (entry_t)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .wdata (wdata[i]),
      .pop   (pop[i]),
      .head  (head[i]),
      .count (count[i])
    );
  end

  assign bus.src_ready_o = ~full;
  assign bus.idle_o      = &empty;

  // Scan heads from rr; the first grant takes port 1, the next head whose address
  // differs from it takes port 2. Conflicting heads simply wait for a later cycle.
  always_comb begin
    logic [RrWidth-1:0] idx;
    logic [1:0]         n_grant;
    pop       = '0;
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    rr_d      = rr_q;
    n_grant   = 2'd0;
    idx       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = rr_q + RrWidth'(k);
      if (!empty[idx]) begin
        if (ZeroDrop && (head[idx].addr == '0)) begin
          pop[idx] = 1'b1;
        end else if (n_grant == 2'd0) begin
          pop[idx]     = 1'b1;
          wr_en_d[0]   = 1'b1;
          wr_addr_d[0] = head[idx].addr;
          wr_data_d[0] = head[idx].data;
          rr_d         = idx + 1'b1;
          n_grant      = 2'd1;
        end else if ((n_grant == 2'd1) && (head[idx].addr != wr_addr_d[0])) begin
          pop[idx]     = 1'b1;
          wr_en_d[1]   = 1'b1;
          wr_addr_d[1] = head[idx].addr;
          wr_data_d[1] = head[idx].data;
          rr_d         = idx + 1'b1;
          n_grant      = 2'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr1_en_o   = wr_en_q[0];
  assign bus.wr2_en_o   = wr_en_q[1];
  assign bus.wr1_addr_o = wr_addr_q[0];
  assign bus.wr2_addr_o = wr_addr_q[1];
  assign bus.wr1_data_o = wr_data_q[0];
  assign bus.wr2_data_o = wr_data_q[1];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model of the arbiter.
// Honours WB_ZERO_DROP_EN the same way the design does.
module tb_wb_port_arbiter;
  import wb_pkg::*;

`ifdef WB_ZERO_DROP_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  wb_entry_t   q [NUM_SRC][$];
  int unsigned rr_m = 0;

  wb_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  wb_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr1_en"}, 64'(bus.wr1_en_o), 64'd0);
    chk({tag, "_wr1_addr"}, 64'(bus.wr1_addr_o), 64'd0);
    chk({tag, "_wr1_data"}, 64'(bus.wr1_data_o), 64'd0);
    chk({tag, "_wr2_en"}, 64'(bus.wr2_en_o), 64'd0);
    chk({tag, "_wr2_addr"}, 64'(bus.wr2_addr_o), 64'd0);
    chk({tag, "_wr2_data"}, 64'(bus.wr2_data_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.src_ready_o), 64'hF);
    chk({tag, "_idle"}, 64'(bus.idle_o), 64'd1);
  endtask

  // Asserts reset immediately (whatever the clock phase), checks the outputs
  // cleared at once, empties the model, then releases on a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_outputs_zero(tag);
    for (int i = 0; i < NUM_SRC; i++) q[i].delete();
    rr_m = 0;
    bus.src_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: check ready/idle against the model, predict the registered
  // write ports from the buffered heads, apply the model's pops and pushes,
  // then compare the write ports just after the edge.
  task automatic tick();
    logic [3:0]  exp_ready;
    logic        e_en1, e_en2;
    logic [4:0]  e_a1, e_a2;
    logic [31:0] e_d1, e_d2;
    int          ngr, last, total;
    total = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      exp_ready[i] = (q[i].size() < 2);
      total += q[i].size();
    end
    chk("src_ready", 64'(bus.src_ready_o), 64'(exp_ready));
    chk("idle", 64'(bus.idle_o), 64'(total == 0));
    e_en1 = 0; e_en2 = 0; e_a1 = 0; e_a2 = 0; e_d1 = 0; e_d2 = 0;
    ngr = 0;
    last = -1;
    for (int k = 0; k < NUM_SRC; k++) begin
      int s;
      s = (int'(rr_m) + k) % NUM_SRC;
      if (q[s].size() == 0) continue;
      if (ZD && q[s][0].addr == 5'd0) begin
        void'(q[s].pop_front());
        continue;
      end
      if (ngr == 0) begin
        e_en1 = 1; e_a1 = q[s][0].addr; e_d1 = q[s][0].data;
        void'(q[s].pop_front());
        ngr = 1; last = s;
      end else if (ngr == 1 && q[s][0].addr != e_a1) begin
        e_en2 = 1; e_a2 = q[s][0].addr; e_d2 = q[s][0].data;
        void'(q[s].pop_front());
        ngr = 2; last = s;
      end
    end
    if (last >= 0) rr_m = unsigned'((last + 1) % NUM_SRC);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_valid_i[i] && exp_ready[i]) begin
        wb_entry_t e;
        e.addr = bus.src_addr_i[i];
        e.data = bus.src_data_i[i];
        q[i].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("wr1_en", 64'(bus.wr1_en_o), 64'(e_en1));
    chk("wr1_addr", 64'(bus.wr1_addr_o), 64'(e_a1));
    chk("wr1_data", 64'(bus.wr1_data_o), 64'(e_d1));
    chk("wr2_en", 64'(bus.wr2_en_o), 64'(e_en2));
    chk("wr2_addr", 64'(bus.wr2_addr_o), 64'(e_a2));
    chk("wr2_data", 64'(bus.wr2_data_o), 64'(e_d2));
  endtask

  initial begin
    logic [31:0] d1, d2;
    bus.src_valid_i = '0;
    bus.src_addr_i  = '0;
    bus.src_data_i  = '0;
    #1;
    do_reset("reset");

    // Single result: visible one cycle after the accepting edge, on port 1.
    bus.src_valid_i   = 4'b0001;
    bus.src_addr_i[0] = 5'd3;
    bus.src_data_i[0] = 32'hAAAA_0001;
    tick();
    chk("single_latency_en", 64'(bus.wr1_en_o), 64'd0);
    bus.src_valid_i = '0;
    tick();
    chk("single_wr1_en", 64'(bus.wr1_en_o), 64'd1);
    chk("single_wr1_addr", 64'(bus.wr1_addr_o), 64'd3);
    chk("single_wr1_data", 64'(bus.wr1_data_o), 64'hAAAA_0001);
    chk("single_wr2_en", 64'(bus.wr2_en_o), 64'd0);

    // Four sources at once from rr=0: addrs 1/2 then 3/4.
    do_reset("reset2");
    bus.src_valid_i = 4'b1111;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_addr_i[i] = 5'(i + 1);
      bus.src_data_i[i] = $urandom;
    end
    tick();
    bus.src_valid_i = '0;
    tick();
    chk("four_c1_a1", 64'(bus.wr1_addr_o), 64'd1);
    chk("four_c1_a2", 64'(bus.wr2_addr_o), 64'd2);
    tick();
    chk("four_c2_a1", 64'(bus.wr1_addr_o), 64'd3);
    chk("four_c2_a2", 64'(bus.wr2_addr_o), 64'd4);
    chk("four_rr_end", 64'(rr_m), 64'd0);
    tick();

    // Address conflict: sources 1 and 2 both target register 7.
    do_reset("reset3");
    d1 = $urandom;
    d2 = $urandom;
    bus.src_valid_i   = 4'b0110;
    bus.src_addr_i[1] = 5'd7;
    bus.src_addr_i[2] = 5'd7;
    bus.src_data_i[1] = d1;
    bus.src_data_i[2] = d2;
    tick();
    bus.src_valid_i = '0;
    tick();
    chk("conflict_c1_data", 64'(bus.wr1_data_o), 64'(d1));
    chk("conflict_c1_wr2", 64'(bus.wr2_en_o), 64'd0);
    tick();
    chk("conflict_c2_data", 64'(bus.wr1_data_o), 64'(d2));
    tick();

    // Back-pressure on source 3 while all sources compete.
    do_reset("reset4");
    bus.src_valid_i = 4'b1111;
    for (int i = 0; i < NUM_SRC; i++) bus.src_addr_i[i] = 5'(i + 8);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NUM_SRC; i++) bus.src_data_i[i] = $urandom;
      tick();
      if (c == 1) chk("bp_src3_full", 64'(bus.src_ready_o[3]), 64'd0);
      if (c == 2) chk("bp_src3_free", 64'(bus.src_ready_o[3]), 64'd1);
    end
    bus.src_valid_i = '0;
    for (int c = 0; c < 6; c++) tick();

    // Asynchronous reset with five results buffered.
    do_reset("reset5");
    bus.src_valid_i = 4'b1111;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_addr_i[i] = 5'(i + 12);
      bus.src_data_i[i] = $urandom;
    end
    tick();
    bus.src_valid_i = 4'b0111;
    tick();
    #2;
    do_reset("midrst");
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_no_write", 64'({bus.wr1_en_o, bus.wr2_en_o}), 64'd0);
    end

    // Register-0 result followed by register 5 from source 0.
    do_reset("reset6");
    bus.src_valid_i   = 4'b0001;
    bus.src_addr_i[0] = 5'd0;
    bus.src_data_i[0] = 32'h0000_00F0;
    tick();
    bus.src_addr_i[0] = 5'd5;
    bus.src_data_i[0] = 32'h0000_00F5;
    tick();
    chk("zero_c1_en", 64'(bus.wr1_en_o), ZD ? 64'd0 : 64'd1);
    bus.src_valid_i = '0;
    tick();
    chk("zero_c2_addr", 64'(bus.wr1_addr_o), ZD ? 64'd5 : 64'd5);
    chk("zero_c2_en", 64'(bus.wr1_en_o), 64'd1);
    tick();

    // Random traffic with a narrow address range to provoke conflicts.
    for (int c = 0; c < 400; c++) begin
      bus.src_valid_i = 4'($urandom);
      for (int i = 0; i < NUM_SRC; i++) begin
        bus.src_addr_i[i] = 5'($urandom_range(0, 7));
        bus.src_data_i[i] = $urandom;
      end
      tick();
    end
    bus.src_valid_i = '0;
    for (int c = 0; c < 6; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the result data width.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the destination register index width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 src_valid_i  input  4  SHALL mark a result offered by source i (bit i).
REQ-006 src_ready_o  output  4  SHALL mark that source i's result is accepted this cycle.
REQ-007 src_addr_i  input  4 x ADDR_WIDTH  SHALL carry the destination register index per source.
REQ-008 src_data_i  input  4 x DATA_WIDTH  SHALL carry the result data per source.
REQ-009 wr1_en_o, wr2_en_o  output  1 each  SHALL be the write enables of register-file write ports 1 and 2.
REQ-010 wr1_addr_o, wr2_addr_o  output  ADDR_WIDTH each  SHALL be the write port destination indices.
REQ-011 wr1_data_o, wr2_data_o  output  DATA_WIDTH each  SHALL be the write port data.
REQ-012 idle_o  output  1  SHALL be high when every source buffer is empty.

Function
REQ-013 Each source SHALL own a 2-entry FIFO; a transfer occurs when src_valid_i[i] and src_ready_o[i] are both high at a rising edge.
REQ-014 src_ready_o[i] SHALL be high exactly when FIFO i holds fewer than 2 entries, independent of src_valid_i and of a same-cycle pop.
REQ-015 Each cycle, the arbiter SHALL grant up to 2 non-empty FIFO heads, scanning sources in round-robin order starting at pointer rr (0..3).
REQ-016 The first grant SHALL drive write port 1 and the second write port 2; granted heads SHALL be popped at the same edge the outputs are registered.
REQ-017 After any grant, rr SHALL advance to one past the last granted source, modulo 4; with no grant, rr SHALL hold.
REQ-018 When two candidate heads target the same address, only the first in scan order SHALL be granted that cycle; the scan SHALL continue to the next non-conflicting head.
REQ-019 All wr*_o outputs SHALL be registered; a result accepted at edge E SHALL appear on a write port no earlier than the cycle following edge E+1.
REQ-020 wrN_en_o SHALL be low in any cycle with no grant for port N; wrN_addr_o/wrN_data_o SHALL then be zero.
REQ-021 Entries from one source SHALL be written in acceptance order.
REQ-022 With all four FIFOs full and no conflicts, throughput SHALL be 2 writes per cycle, and no source SHALL wait more than 2 cycles once at FIFO head.

Reset
REQ-023 Asserting rst SHALL immediately clear all FIFOs, set rr to 0, and drive wr*_en_o/addr/data to 0, src_ready_o to 4'b1111, and idle_o to 1.
REQ-024 Reset asserted mid-operation SHALL discard buffered results without emitting any write.

Configuration
REQ-025 With macro WB_ZERO_DROP_EN defined, accepted entries addressed to register 0 SHALL be popped at the FIFO head without consuming a write port or asserting any wr*_en_o.
REQ-026 Without WB_ZERO_DROP_EN, register-0 entries SHALL be arbitrated and written like any other address.

Structure
REQ-027 Package wb_pkg SHALL hold NUM_SRC = 4, NUM_WPORT = 2, and typedef wb_entry_t {addr, data}.
REQ-028 The per-source buffer SHALL be sub-module wb_src_fifo (2-entry, push/pop/count); four instances are used.

Verification
REQ-029 Reset, then source 0 pushes addr 3 data 0xAAAA_0001 -> wr1_en_o=1, addr 3, data 0xAAAA_0001 in the cycle after the next edge; wr2_en_o=0.
REQ-030 All 4 sources push once (addrs 1,2,3,4) with rr=0 -> cycle 1: ports 1/2 write addrs 1/2; cycle 2: addrs 3/4; rr ends at 0.
REQ-031 Sources 1 and 2 both head with addr 7 -> only source 1 written that cycle; source 2 written next cycle.
REQ-032 Source 3 pushes 3 back-to-back while outputs are held busy by other sources -> src_ready_o[3] low after 2 accepted; third accepted only after a pop.
REQ-033 rst asserted asynchronously while 5 entries are buffered -> all outputs zero immediately, idle_o=1, no writes after release.
REQ-034 With WB_ZERO_DROP_EN, source 0 pushes addr 0 then addr 5 -> no write for addr 0; addr 5 written on port 1.
